// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction RAM writer.
// Receives a length-prefixed little-endian byte stream and writes 32-bit words
// sequentially from INSTR_SEG_BEGIN, holding the core in reset until the load
// completes cleanly.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte (state CHK) that must match before the load is reported done.
module imem_loader #(
  parameter logic [31:0] INSTR_SEG_BEGIN = 32'h0000_2000,
  parameter int          MAX_WORDS       = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [31:0] addr_imem_ram_o,
  output logic [31:0] wr_instr_imem_ram_o,
  output logic        wr_en_imem_ram_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        cpu_rst_n_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHK   = 3'd6,
`endif
    S_ERR   = 3'd5
  } state_t;

  localparam logic [16:0] LP_MAX_LEN = 17'(MAX_WORDS);

  state_t      r_state;
  logic [1:0]  r_byte_cnt;
  logic [11:0] r_idx;
  logic [15:0] r_len;
  logic [31:0] r_word;
  logic        r_rx_ready;
  logic [31:0] r_addr;
  logic [31:0] r_wr_instr;
  logic        r_wr_en;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic        r_cpu_rst_n;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  r_csum;
`endif

  logic        w_accept;
  logic [15:0] w_len;
  logic [11:0] w_idx_p1;
  logic        w_last;
  logic [31:0] w_addr_next;
  logic [31:0] w_word_next;

  assign w_accept    = rx_valid_i && r_rx_ready;
  // Second length byte completes the count; first byte is already in r_len[7:0].
  assign w_len       = {rx_data_i, r_len[7:0]};
  assign w_idx_p1    = r_idx + 12'd1;
  assign w_last      = ({4'd0, w_idx_p1} == r_len);
  assign w_addr_next = INSTR_SEG_BEGIN + {18'd0, r_idx, 2'b00};
  // Bytes shift in from the top so the first byte lands in bits [7:0].
  assign w_word_next = {rx_data_i, r_word[31:8]};

  // Loader FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_byte_cnt  <= 2'd0;
      r_idx       <= 12'd0;
      r_len       <= 16'd0;
      r_word      <= 32'd0;
      r_rx_ready  <= 1'b0;
      r_addr      <= INSTR_SEG_BEGIN;
      r_wr_instr  <= 32'd0;
      r_wr_en     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_cpu_rst_n <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum      <= 8'd0;
`endif
    end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
      // Running XOR of every length/payload byte; CHK compares rather than folds.
      if (w_accept && (r_state != S_CHK)) begin
        r_csum <= r_csum ^ rx_data_i;
      end
`endif
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          r_wr_en <= 1'b0;
          if (start_i) begin
            r_state     <= S_LEN;
            r_byte_cnt  <= 2'd0;
            r_idx       <= 12'd0;
            r_rx_ready  <= 1'b1;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cpu_rst_n <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum      <= 8'd0;
`endif
          end
        end

        S_LEN: begin
          if (w_accept) begin
            if (r_byte_cnt == 2'd0) begin
              r_len[7:0] <= rx_data_i;
              r_byte_cnt <= 2'd1;
            end else begin
              r_len      <= w_len;
              r_byte_cnt <= 2'd0;
              if (w_len == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_state     <= S_CHK;
`else
                r_state     <= S_DONE;
                r_rx_ready  <= 1'b0;
                r_busy      <= 1'b0;
                r_done      <= 1'b1;
                r_cpu_rst_n <= 1'b1;
`endif
              end else if ({1'b0, w_len} > LP_MAX_LEN) begin
                r_state     <= S_ERR;
                r_rx_ready  <= 1'b0;
                r_busy      <= 1'b0;
                r_err       <= 1'b1;
                r_cpu_rst_n <= 1'b0;
              end else begin
                r_state <= S_DATA;
              end
            end
          end
        end

        S_DATA: begin
          if (w_accept) begin
            r_word     <= w_word_next;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              // Strobe is raised for exactly the WRITE cycle that follows.
              r_state    <= S_WRITE;
              r_rx_ready <= 1'b0;
              r_wr_en    <= 1'b1;
              r_addr     <= w_addr_next;
              r_wr_instr <= w_word_next;
            end
          end
        end

        S_WRITE: begin
          r_wr_en    <= 1'b0;
          r_byte_cnt <= 2'd0;
          if (w_last) begin
            // idx stays at N-1 so it never reaches MAX_WORDS.
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_state     <= S_CHK;
            r_rx_ready  <= 1'b1;
`else
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_cpu_rst_n <= 1'b1;
`endif
          end else begin
            r_idx      <= w_idx_p1;
            r_state    <= S_DATA;
            r_rx_ready <= 1'b1;
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (w_accept) begin
            r_rx_ready <= 1'b0;
            r_busy     <= 1'b0;
            if (rx_data_i == r_csum) begin
              r_state     <= S_DONE;
              r_done      <= 1'b1;
              r_cpu_rst_n <= 1'b1;
            end else begin
              r_state     <= S_ERR;
              r_err       <= 1'b1;
              r_cpu_rst_n <= 1'b0;
            end
          end
        end
`endif

        default: begin
          r_state     <= S_IDLE;
          r_rx_ready  <= 1'b0;
          r_wr_en     <= 1'b0;
          r_busy      <= 1'b0;
          r_cpu_rst_n <= 1'b0;
        end
      endcase
    end
  end

  assign rx_ready_o          = r_rx_ready;
  assign addr_imem_ram_o     = r_addr;
  assign wr_instr_imem_ram_o = r_wr_instr;
  assign wr_en_imem_ram_o    = r_wr_en;
  assign busy_o              = r_busy;
  assign done_o              = r_done;
  assign err_o               = r_err;
  assign cpu_rst_n_o         = r_cpu_rst_n;

endmodule
